// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings for the pc sequencer: FSM states, opcode/ext fields,
// condition codes, flag bit positions and the instruction class decoder.
package pc_seq_ctrl_pkg;

  localparam int PC_DATA_W = 16;
  localparam int PC_DISP_W = 8;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_MEM    = 2'd3
  } state_t;

  localparam logic [3:0] OP_JMP    = 4'h4;
  localparam logic [3:0] OP_BCOND  = 4'hC;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    K_ALU, K_BCOND, K_JCOND, K_JAL, K_LOAD, K_STOR, K_NOP
  } ikind_t;

  function automatic ikind_t decode_kind(input logic [3:0] op, input logic [3:0] ext);
    ikind_t k;
    k = K_ALU;
    if (op == OP_BCOND) begin
      k = K_BCOND;
    end else if (op == OP_JMP) begin
      case (ext)
        EXT_JCOND: k = K_JCOND;
        EXT_JAL:   k = K_JAL;
        EXT_LOAD:  k = K_LOAD;
        EXT_STOR:  k = K_STOR;
        default:   k = K_NOP;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Memory port and pc/regfile control strobes of the sequencer.
// Handshake: mem_req is held stable until a cycle with mem_ack=1, which
// completes the request in that same cycle (ack may arrive with the request).
interface pc_seq_ctrl_if
  import pc_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = PC_DATA_W,
  parameter int DISP_W = PC_DISP_W
);
  logic              mem_req;
  logic              mem_we;
  logic              addr_sel;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              pcEn;
  logic              branch;
  logic              jump;
  logic              link_we;
  logic              rf_we;
  logic [DISP_W-1:0] disp;

  modport master (
    output mem_req, mem_we, addr_sel, pcEn, branch, jump, link_we, rf_we, disp,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, addr_sel, pcEn, branch, jump, link_we, rf_we, disp,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/pc_seq_ctrl_cond_eval.sv
// Combinational condition evaluator: 4-bit condition code against {C,L,F,Z,N}.
module pc_seq_ctrl_cond_eval
  import pc_seq_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       cond_ok_o
);

  always_comb begin
    cond_ok_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ok_o = flags_i[FLAG_Z];
      COND_NE: cond_ok_o = ~flags_i[FLAG_Z];
      COND_CS: cond_ok_o = flags_i[FLAG_C];
      COND_CC: cond_ok_o = ~flags_i[FLAG_C];
      COND_HI: cond_ok_o = flags_i[FLAG_L];
      COND_LS: cond_ok_o = ~flags_i[FLAG_L];
      COND_GT: cond_ok_o = flags_i[FLAG_N];
      COND_LE: cond_ok_o = ~flags_i[FLAG_N];
      COND_FS: cond_ok_o = flags_i[FLAG_F];
      COND_FC: cond_ok_o = ~flags_i[FLAG_F];
      COND_LO: cond_ok_o = ~flags_i[FLAG_L] & ~flags_i[FLAG_Z];
      COND_HS: cond_ok_o = flags_i[FLAG_L] | flags_i[FLAG_Z];
      COND_LT: cond_ok_o = ~flags_i[FLAG_N] & ~flags_i[FLAG_Z];
      COND_GE: cond_ok_o = flags_i[FLAG_N] | flags_i[FLAG_Z];
      COND_UC: cond_ok_o = 1'b1;
      COND_NV: cond_ok_o = 1'b0;
      default: cond_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXEC (-> MEM), one
// pcEn pulse per instruction, with branch/jump/link decisions for the pc block.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = PC_DATA_W,
  parameter int DISP_W = PC_DISP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic [4:0]        flags_i,
  pc_seq_ctrl_if.master     bus,
  output logic [DATA_W-1:0] ir_o,
  output state_t            state_o
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              cond_ok_q, cond_ok_d;
  logic              cond_ok_w;
  ikind_t            kind;

  pc_seq_ctrl_cond_eval u_cond_eval (
    .cond_i    (ir_q[11:8]),
    .flags_i   (flags_i),
    .cond_ok_o (cond_ok_w)
  );

  assign kind    = decode_kind(ir_q[15:12], ir_q[7:4]);
  assign ir_o    = ir_q;
  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cond_ok_d    = cond_ok_q;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.pcEn     = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    bus.link_we  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.disp     = '0;
    case (state_q)
      ST_FETCH: begin
        // An ack while stopped is ignored so a late memory response cannot restart us.
        bus.mem_req = run_i;
        if (run_i && bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Flags are frozen here; later flag updates must not change the decision.
        cond_ok_d = cond_ok_w;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (kind)
          K_ALU: begin
            bus.rf_we = 1'b1;
            bus.pcEn  = 1'b1;
          end
          K_BCOND: begin
            bus.pcEn   = 1'b1;
            bus.branch = cond_ok_q;
            bus.disp   = ir_q[DISP_W-1:0];
          end
          K_JCOND: begin
            bus.pcEn = 1'b1;
            bus.jump = cond_ok_q;
          end
          K_JAL: begin
            bus.pcEn    = 1'b1;
            bus.jump    = 1'b1;
            bus.link_we = 1'b1;
          end
          K_LOAD, K_STOR: state_d = ST_MEM;
          default: bus.pcEn = 1'b1;
        endcase
      end
      ST_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = (kind == K_STOR);
        if (bus.mem_ack) begin
          bus.rf_we = (kind == K_LOAD);
          bus.pcEn  = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed cases plus random instruction streams
// checked against an instruction-level reference model and a pc model.
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [4:0]  flags;
  logic [15:0] ir;
  logic [1:0]  state;

  pc_seq_ctrl_if bus ();

  pc_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run),
    .flags_i (flags),
    .bus     (bus),
    .ir_o    (ir),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pc;
  logic [15:0] link_val;

  typedef struct {
    int          pc_cycle;
    logic        br;
    logic        jp;
    int          lk_cnt;
    int          rf_cnt;
    logic        mwe;
    logic [15:0] next_pc;
    logic [15:0] link;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conditions come in true/complement pairs; odd codes negate the even one.
  function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn, base;
    {fc, fl, ff, fz, fn} = f;
    case (c[3:1])
      3'd0:    base = fz;
      3'd1:    base = fc;
      3'd2:    base = fl;
      3'd3:    base = fn;
      3'd4:    base = ff;
      3'd5:    base = !fl && !fz;
      3'd6:    base = !fn && !fz;
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic exp_t model(input logic [15:0] ins, input logic [4:0] f,
                                 input logic [15:0] pc0, input logic [15:0] dst,
                                 input int fw, input int mw);
    exp_t e;
    logic [3:0] op, ext;
    logic ok;
    bit mem_op;
    op  = ins[15:12];
    ext = ins[7:4];
    ok  = cond_ref(ins[11:8], f);
    e.br = 1'b0; e.jp = 1'b0; e.lk_cnt = 0; e.rf_cnt = 0; e.mwe = 1'b0;
    mem_op = (op == 4'h4) && (ext == 4'h0 || ext == 4'h4);
    e.pc_cycle = mem_op ? fw + 3 + mw : fw + 2;
    if (op == 4'hC) e.br = ok;
    else if (op == 4'h4) begin
      if (ext == 4'hC) e.jp = ok;
      else if (ext == 4'h8) begin e.jp = 1'b1; e.lk_cnt = 1; end
      else if (ext == 4'h0) e.rf_cnt = 1;
      else if (ext == 4'h4) e.mwe = 1'b1;
    end else e.rf_cnt = 1;
    e.next_pc = e.br ? pc0 + {{8{ins[7]}}, ins[7:0]} : (e.jp ? dst : pc0 + 16'd1);
    e.link    = pc0 + 16'd1;
    return e;
  endfunction

  // One instruction through a memory with fw fetch and mw data wait cycles.
  task automatic do_instr(input logic [15:0] ins, input logic [4:0] fdec, input logic [15:0] dst,
                          input int fw, input int mw, input bit drop_run);
    exp_t e;
    int cyc = 0, fcnt = 0, mcnt = 0, ack_cyc = -1, pc_cyc = -1, pc_n = 0, rf_n = 0, lk_n = 0;
    bit fetched = 0, done = 0, mwe_seen = 0, req_bad = 0, excl_bad = 0, in_mem = 0;
    logic br_s = 0, jp_s = 0, mwe_first = 0;
    logic [7:0] disp_s = 0;
    logic [15:0] ir_s = 0, want;
    e = model(ins, fdec, pc, dst, fw, mw);
    exp_q.push_back(e.next_pc);
    while (!done && cyc < 40) begin
      @(negedge clk);
      run = !fetched || !drop_run;
      flags = (fetched && cyc == ack_cyc + 1) ? fdec : 5'($urandom);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 16'($urandom);
      #1;
      if (bus.mem_req && !bus.addr_sel && !fetched) begin
        if (fcnt == fw) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = ins; fetched = 1; ack_cyc = cyc;
        end else fcnt++;
      end else if (bus.addr_sel) begin
        if (!in_mem) begin in_mem = 1; mwe_first = bus.mem_we; end
        if (!bus.mem_req || bus.mem_we !== mwe_first) req_bad = 1;
        if (mcnt == mw) bus.mem_ack = 1'b1; else mcnt++;
      end
      #1;
      if (bus.rf_we) rf_n++;
      if (bus.link_we) lk_n++;
      if (bus.mem_we) mwe_seen = 1;
      if (bus.branch && bus.jump) excl_bad = 1;
      if (bus.pcEn) begin
        if (state != 2'd2 && state != 2'd3) excl_bad = 1;
        pc_n++; pc_cyc = cyc; br_s = bus.branch; jp_s = bus.jump; disp_s = bus.disp; ir_s = ir;
        if (bus.link_we) link_val = pc + 16'd1;
        if (bus.branch) pc = pc + {{8{bus.disp[7]}}, bus.disp};
        else if (bus.jump) pc = dst;
        else pc = pc + 16'd1;
        done = 1;
      end
      @(posedge clk);
      cyc++;
    end
    want = exp_q.pop_front();
    check("pcEn_count", 32'(pc_n), 32'd1);
    check("pcEn_cycle", 32'(pc_cyc), 32'(e.pc_cycle));
    check("branch", 32'(br_s), 32'(e.br));
    check("jump", 32'(jp_s), 32'(e.jp));
    check("link_we", 32'(lk_n), 32'(e.lk_cnt));
    check("rf_we", 32'(rf_n), 32'(e.rf_cnt));
    check("mem_we", 32'(mwe_seen), 32'(e.mwe));
    check("mem_hold", 32'(req_bad), 32'd0);
    check("strobe_rules", 32'(excl_bad), 32'd0);
    check("ir", 32'(ir_s), 32'(ins));
    check("pc", 32'(pc), 32'(want));
    if (e.lk_cnt != 0) check("link", 32'(link_val), 32'(e.link));
    if (ins[15:12] == 4'hC) check("disp", 32'(disp_s), 32'(ins[7:0]));
    if (drop_run) begin
      @(negedge clk);
      run = 1'b0;
      #2;
      check("stop_req", 32'(bus.mem_req), 32'd0);
      check("stop_state", 32'(state), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  op, ext;
    rst = 1'b1; run = 1'b0; flags = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    pc = 16'd0; link_val = 16'd0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_strobes", 32'({bus.pcEn, bus.rf_we, bus.link_we, bus.branch, bus.jump,
                              bus.mem_req, bus.mem_we, bus.addr_sel}), 32'd0);
    check("rst_disp", 32'(bus.disp), 32'd0);
    @(negedge clk); rst = 1'b0;

    do_instr(16'h0123, 5'd0, 16'h0, 0, 0, 0);
    pc = 16'd1; do_instr(16'hC07F, 5'b00010, 16'h0, 0, 0, 0);
    pc = 16'd1; do_instr(16'hC07F, 5'b00000, 16'h0, 0, 0, 0);
    pc = 16'h8000; do_instr(16'h4E83, 5'($urandom), 16'hFFFF, 0, 0, 0);
    do_instr(16'h4203, 5'd0, 16'h0, 1, 3, 0);
    do_instr(16'h4FC5, 5'($urandom), 16'h1234, 0, 0, 0);
    do_instr(16'h4EC5, 5'($urandom), 16'h5678, 0, 0, 0);
    do_instr(16'h4045, 5'd0, 16'h0, 2, 0, 0);
    do_instr(16'h4021, 5'd0, 16'h0, 0, 0, 1);

    // Asynchronous reset while a LOAD sits in MEM waiting for ack.
    @(negedge clk); run = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h4305;
    @(posedge clk);
    @(negedge clk); bus.mem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); run = 1'b0;
    #1;
    check("mem_state", 32'(state), 32'd3);
    check("mem_req", 32'(bus.mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_strobes", 32'({bus.pcEn, bus.rf_we, bus.link_we, bus.branch, bus.jump,
                               bus.mem_req, bus.mem_we, bus.addr_sel}), 32'd0);
    check("arst_ir", 32'(ir), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = 1'b0;
      bus.mem_ack = 1'($urandom);
      #1;
      check("idle_req", 32'(bus.mem_req), 32'd0);
      check("idle_pcen", 32'(bus.pcEn), 32'd0);
      check("idle_state", 32'(state), 32'd0);
    end
    bus.mem_ack = 1'b0;

    pc = 16'($urandom);
    for (int n = 0; n < 80; n++) begin
      op  = 4'($urandom);
      ext = 4'($urandom);
      case ($urandom_range(0, 5))
        0: begin if (op == 4'h4) op = 4'h5; if (op == 4'hC) op = 4'hD; end
        1: op = 4'hC;
        2: begin op = 4'h4; ext = 4'hC; end
        3: begin op = 4'h4; ext = 4'h8; end
        4: begin op = 4'h4; ext = ($urandom_range(0, 1) != 0) ? 4'h4 : 4'h0; end
        default: begin op = 4'h4; ext = {2'($urandom), 2'($urandom_range(1, 3))}; end
      endcase
      ins = {op, 4'($urandom), ext, 4'($urandom)};
      do_instr(ins, 5'($urandom), 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
